// File: rtl/pkt_wr_buf_pkg.sv
// Shared constants, FSM state encoding and the checksum-clear helper
// for the packet write buffer.
package pkt_wr_buf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 64;
    localparam int PTR_W      = 6;
    localparam int LEN_W      = 7;
    localparam int CSUM_WORD  = 6;
    localparam int CSUM_LSB   = 16;

    localparam logic                  RST_ENABLED = 1'b0;
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD   = '0;
    localparam logic [15:0]           ZERO_HALF   = '0;

    typedef enum logic [1:0] {
        PKTW_IDLE = 2'd0,
        PKTW_RECV = 2'd1,
        PKTW_HOLD = 2'd2,
        PKTW_DROP = 2'd3
    } pktw_state_t;

    function automatic logic [DATA_WIDTH-1:0] clear_csum(input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] r_word;
        r_word                   = word;
        r_word[CSUM_LSB +: 16]   = ZERO_HALF;
        return r_word;
    endfunction

endpackage

// File: rtl/pkt_wr_buf_if.sv
// Valid/ready word stream feeding the packet write buffer.
interface pkt_wr_buf_if;
    import pkt_wr_buf_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/pkt_dpram.sv
// 1-write/1-read packet memory; registered read returns old data when
// the same word is written in the same cycle.
module pkt_dpram
    import pkt_wr_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is never reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            r_rdata <= ZERO_WORD;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_wr_buf.sv
// Packet write buffer: stores one packet of up to DEPTH words, clears the
// checksum field on the way in and holds the packet until released.
//
//   state | meaning
//   IDLE  | empty, waiting for word 0
//   RECV  | storing words 1..DEPTH-1
//   HOLD  | packet stored, reader owns the buffer until i_release
//   DROP  | packet too long, swallowing words until in_last
module pkt_wr_buf
    import pkt_wr_buf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    pkt_wr_buf_if.slave           s_in,
    input  logic                  i_release,
    output logic                  o_pkt_done,
    output logic                  o_pkt_err,
    output logic [LEN_W-1:0]      o_pkt_len,
    output logic                  o_busy,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    pktw_state_t           r_state;
    pktw_state_t           w_state_nxt;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [LEN_W-1:0]      r_pkt_len;
    logic [LEN_W-1:0]      w_pkt_len_nxt;
    logic                  r_in_ready;
    logic                  r_pkt_done;
    logic                  r_pkt_err;
    logic                  w_xfer;
    logic                  w_we;
    logic [PTR_W-1:0]      w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_busy;
    logic                  w_addr_unused;

    assign w_xfer = s_in.in_valid & r_in_ready;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            r_state    <= PKTW_IDLE;
            r_wr_ptr   <= '0;
            r_pkt_len  <= '0;
            r_in_ready <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_pkt_len  <= w_pkt_len_nxt;
            r_in_ready <= (w_state_nxt != PKTW_HOLD);
            r_pkt_done <= (w_state_nxt == PKTW_HOLD) && (r_state != PKTW_HOLD);
            r_pkt_err  <= (r_state == PKTW_DROP) && (w_state_nxt == PKTW_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_pkt_len_nxt = r_pkt_len;
        case (r_state)
            PKTW_IDLE: begin
                if (w_xfer) begin
                    w_wr_ptr_nxt = PTR_W'(1);
                    if (s_in.in_last) begin
                        w_state_nxt   = PKTW_HOLD;
                        w_pkt_len_nxt = LEN_W'(1);
                    end else begin
                        w_state_nxt = PKTW_RECV;
                    end
                end
            end
            PKTW_RECV: begin
                if (w_xfer) begin
                    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    if (s_in.in_last) begin
                        w_state_nxt   = PKTW_HOLD;
                        w_pkt_len_nxt = {1'b0, r_wr_ptr} + LEN_W'(1);
                    end else if (r_wr_ptr == PTR_W'(DEPTH - 1)) begin
                        w_state_nxt = PKTW_DROP;
                    end
                end
            end
            PKTW_HOLD: begin
                if (i_release) begin
                    w_state_nxt  = PKTW_IDLE;
                    w_wr_ptr_nxt = '0;
                end
            end
            PKTW_DROP: begin
                if (w_xfer && s_in.in_last) begin
                    w_state_nxt  = PKTW_IDLE;
                    w_wr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt  = PKTW_IDLE;
                w_wr_ptr_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_busy  = (r_state == PKTW_RECV) || (r_state == PKTW_HOLD);
        w_we    = w_xfer && ((r_state == PKTW_IDLE) || (r_state == PKTW_RECV));
        w_waddr = (r_state == PKTW_IDLE) ? '0 : r_wr_ptr;
        w_wdata = s_in.in_data;
        if (w_waddr == PTR_W'(CSUM_WORD)) begin
            w_wdata = clear_csum(s_in.in_data);
        end
    end

    pkt_dpram u_dpram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (i_addr[2 +: PTR_W]),
        .o_rdata (o_data)
    );

    // Byte lanes within a word are not addressable on the read port.
    assign w_addr_unused = ^i_addr[1:0];

    assign s_in.in_ready = r_in_ready;
    assign o_pkt_done    = r_pkt_done;
    assign o_pkt_err     = r_pkt_err;
    assign o_pkt_len     = r_pkt_len;
    assign o_busy        = w_busy;

endmodule

// File: tb/tb_pkt_wr_buf.sv
// Self-checking bench for pkt_wr_buf: packet table, random packets against a
// word-array model, and hand-written reset/release sequences.
module tb_pkt_wr_buf;
    import pkt_wr_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_release;
    logic        o_pkt_done;
    logic        o_pkt_err;
    logic [6:0]  o_pkt_len;
    logic        o_busy;
    logic [7:0]  i_addr;
    logic [31:0] o_data;

    always #5 clk = ~clk;

    pkt_wr_buf_if u_if ();

    pkt_wr_buf dut (
        .clk        (clk),
        .rst        (rst),
        .s_in       (u_if),
        .i_release  (i_release),
        .o_pkt_done (o_pkt_done),
        .o_pkt_err  (o_pkt_err),
        .o_pkt_len  (o_pkt_len),
        .o_busy     (o_busy),
        .i_addr     (i_addr),
        .o_data     (o_data)
    );

    typedef struct {
        int n;
        int gap;
        bit rel;
        bit exp_done;
        int exp_len;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_mem [64];
    int          exp_len = 0;
    vec_t        tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i, input logic [31:0] base);
        logic [7:0] b;
        b = 8'(i);
        return base ^ {b, b, b, b};
    endfunction

    // Word 6 keeps only its low half; the checksum half is stored as zero.
    function automatic logic [31:0] model_store(input int idx, input logic [31:0] w);
        return (idx == 6) ? (w & 32'h0000_FFFF) : w;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input int gap);
        int t;
        t = 0;
        while (int'($urandom_range(99, 0)) < gap) begin
            u_if.in_valid = 1'b0;
            @(negedge clk);
        end
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_last  = last;
        while (!u_if.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(u_if.in_ready), 32'd1);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            i_addr = 8'(i * 4);
            @(negedge clk);
            chk($sformatf("mem[%0d]", i), o_data, exp_mem[i]);
        end
    endtask

    task automatic release_buf();
        i_release = 1'b1;
        @(negedge clk);
        i_release = 1'b0;
        chk("rel_busy", 32'(o_busy), 32'd0);
        chk("rel_ready", 32'(u_if.in_ready), 32'd1);
    endtask

    task automatic send_packet(input int n, input int gap, input logic rel,
                               input logic [31:0] base, input logic exp_done, input int exp_l);
        logic [31:0] d;
        i_release = rel;
        for (int i = 0; i < n; i++) begin
            d = pat(i, base);
            if (i < 64) exp_mem[i] = model_store(i, d);
            send_word(d, (i == n - 1), gap);
        end
        i_release = 1'b0;
        if (n <= 64) exp_len = n;
        chk("done_pulse", 32'(o_pkt_done), 32'(exp_done));
        chk("err_pulse", 32'(o_pkt_err), 32'(!exp_done));
        @(negedge clk);
        chk("done_width", 32'(o_pkt_done), 32'd0);
        chk("err_width", 32'(o_pkt_err), 32'd0);
        chk("busy", 32'(o_busy), 32'(exp_done));
        chk("in_ready", 32'(u_if.in_ready), 32'(!exp_done));
        chk("pkt_len", 32'(o_pkt_len), 32'(exp_l));
        if (exp_done) readback(n);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          gap;
        logic        ok;
        int          el;
        logic [31:0] d;

        tbl[0] = '{8,  0,  1'b0, 1'b1, 8};
        tbl[1] = '{1,  0,  1'b0, 1'b1, 1};
        tbl[2] = '{64, 0,  1'b0, 1'b1, 64};
        tbl[3] = '{70, 0,  1'b0, 1'b0, 64};
        tbl[4] = '{20, 50, 1'b0, 1'b1, 20};
        tbl[5] = '{12, 0,  1'b1, 1'b1, 12};
        tbl[6] = '{65, 25, 1'b0, 1'b0, 12};

        rst           = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        u_if.in_data  = '0;
        i_release     = 1'b0;
        i_addr        = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(u_if.in_ready), 32'd0);
        chk("rst_done", 32'(o_pkt_done), 32'd0);
        chk("rst_err", 32'(o_pkt_err), 32'd0);
        chk("rst_len", 32'(o_pkt_len), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_data", o_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(u_if.in_ready), 32'd1);

        for (int r = 0; r < 7; r++) begin
            send_packet(tbl[r].n, tbl[r].gap, tbl[r].rel, (r == 0) ? 32'd0 : $urandom,
                        tbl[r].exp_done, tbl[r].exp_len);
            if (tbl[r].exp_done) release_buf();
        end

        // Word held valid through HOLD is taken two edges after release.
        send_packet(4, 0, 1'b0, $urandom, 1'b1, 4);
        d             = 32'hA5A5_5A5A;
        u_if.in_valid = 1'b1;
        u_if.in_data  = d;
        u_if.in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_ready", 32'(u_if.in_ready), 32'd0);
            chk("hold_done", 32'(o_pkt_done), 32'd0);
        end
        i_release = 1'b1;
        @(negedge clk);
        i_release = 1'b0;
        chk("relh_ready", 32'(u_if.in_ready), 32'd1);
        chk("relh_busy", 32'(o_busy), 32'd0);
        chk("relh_done", 32'(o_pkt_done), 32'd0);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        exp_mem[0]    = d;
        exp_len       = 1;
        chk("held_done", 32'(o_pkt_done), 32'd1);
        chk("held_len", 32'(o_pkt_len), 32'd1);
        chk("held_busy", 32'(o_busy), 32'd1);
        readback(1);
        release_buf();

        // Reset in the middle of a packet abandons it silently.
        for (int i = 0; i < 5; i++) begin
            d          = pat(i, 32'h1357_9BDF);
            exp_mem[i] = model_store(i, d);
            send_word(d, 1'b0, 0);
        end
        chk("mid_busy", 32'(o_busy), 32'd1);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_done", 32'(o_pkt_done), 32'd0);
            chk("mid_rst_err", 32'(o_pkt_err), 32'd0);
            chk("mid_rst_busy", 32'(o_busy), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        exp_len = 0;
        chk("mid_ready", 32'(u_if.in_ready), 32'd1);
        chk("mid_len", 32'(o_pkt_len), 32'd0);
        send_packet(3, 0, 1'b0, $urandom, 1'b1, 3);
        release_buf();

        for (int k = 0; k < 12; k++) begin
            n   = int'($urandom_range(72, 1));
            gap = int'($urandom_range(60, 0));
            ok  = (n <= 64);
            el  = ok ? n : exp_len;
            send_packet(n, gap, 1'b0, $urandom, ok, el);
            if (ok) release_buf();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
